// File: rtl/fp_align_stage.sv
// ----------------------------------------------------------------------------
// fp_align_stage : FP adder exponent compare and mantissa alignment, 2 stages
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_align_stage #(
   parameter int MAN_W = 24,
   parameter int EXT_W = MAN_W + 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       exp_a,
   input  logic [7:0]       exp_b,
   input  logic [MAN_W-1:0] man_a,
   input  logic [MAN_W-1:0] man_b,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic [7:0]       diff,
   input  logic             diff_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             swap,
   output logic [7:0]       exp_big,
   output logic [MAN_W-1:0] man_big,
   output logic             sign_big,
   output logic             sign_small,
   output logic [EXT_W-1:0] man_small_al
);

   logic             s1_valid_q, s1_valid_d;
   logic             s1_swap_q, s1_swap_d;
   logic [7:0]       s1_shamt_q, s1_shamt_d;
   logic [7:0]       s1_exp_q, s1_exp_d;
   logic [MAN_W-1:0] s1_man_big_q, s1_man_big_d;
   logic [MAN_W-1:0] s1_man_small_q, s1_man_small_d;
   logic             s1_sign_big_q, s1_sign_big_d;
   logic             s1_sign_small_q, s1_sign_small_d;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_swap_q, s2_swap_d;
   logic [7:0]       s2_exp_q, s2_exp_d;
   logic [MAN_W-1:0] s2_man_big_q, s2_man_big_d;
   logic             s2_sign_big_q, s2_sign_big_d;
   logic             s2_sign_small_q, s2_sign_small_d;
   logic [EXT_W-1:0] s2_al_q, s2_al_d;

   logic             w_s2_en, w_s1_en, w_accept, w_move;
   logic [EXT_W-1:0] w_ext, w_mask, w_al;
   logic             w_sticky;

   assign w_s2_en  = !s2_valid_q || out_ready;
   assign w_s1_en  = !s1_valid_q || w_s2_en;
   assign w_accept = in_valid && w_s1_en;
   assign w_move   = s1_valid_q && w_s2_en;

   // Shifts of EXT_W or more leave zero data and a mask covering every bit,
   // so the sticky alone carries |man_small without a separate large-shift case.
   assign w_ext    = {s1_man_small_q, 3'b000};
   assign w_mask   = ~({EXT_W{1'b1}} << s1_shamt_q);
   assign w_sticky = |(w_ext & w_mask);
   assign w_al     = (w_ext >> s1_shamt_q) | {{(EXT_W-1){1'b0}}, w_sticky};

   always_comb begin
      s1_valid_d      = w_s1_en ? in_valid : s1_valid_q;
      s1_swap_d       = s1_swap_q;
      s1_shamt_d      = s1_shamt_q;
      s1_exp_d        = s1_exp_q;
      s1_man_big_d    = s1_man_big_q;
      s1_man_small_d  = s1_man_small_q;
      s1_sign_big_d   = s1_sign_big_q;
      s1_sign_small_d = s1_sign_small_q;
      if (w_accept) begin
         s1_swap_d = !diff_cout;
         if (diff_cout) begin
            s1_shamt_d      = diff;
            s1_exp_d        = exp_a;
            s1_man_big_d    = man_a;
            s1_man_small_d  = man_b;
            s1_sign_big_d   = sign_a;
            s1_sign_small_d = sign_b;
         end else begin
            s1_shamt_d      = ~diff + 8'd1;
            s1_exp_d        = exp_b;
            s1_man_big_d    = man_b;
            s1_man_small_d  = man_a;
            s1_sign_big_d   = sign_b;
            s1_sign_small_d = sign_a;
         end
      end
   end

   always_comb begin
      s2_valid_d      = w_s2_en ? s1_valid_q : s2_valid_q;
      s2_swap_d       = s2_swap_q;
      s2_exp_d        = s2_exp_q;
      s2_man_big_d    = s2_man_big_q;
      s2_sign_big_d   = s2_sign_big_q;
      s2_sign_small_d = s2_sign_small_q;
      s2_al_d         = s2_al_q;
      if (w_move) begin
         s2_swap_d       = s1_swap_q;
         s2_exp_d        = s1_exp_q;
         s2_man_big_d    = s1_man_big_q;
         s2_sign_big_d   = s1_sign_big_q;
         s2_sign_small_d = s1_sign_small_q;
         s2_al_d         = w_al;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q      <= 1'b0;
         s1_swap_q       <= 1'b0;
         s1_shamt_q      <= '0;
         s1_exp_q        <= '0;
         s1_man_big_q    <= '0;
         s1_man_small_q  <= '0;
         s1_sign_big_q   <= 1'b0;
         s1_sign_small_q <= 1'b0;
         s2_valid_q      <= 1'b0;
         s2_swap_q       <= 1'b0;
         s2_exp_q        <= '0;
         s2_man_big_q    <= '0;
         s2_sign_big_q   <= 1'b0;
         s2_sign_small_q <= 1'b0;
         s2_al_q         <= '0;
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_swap_q       <= s1_swap_d;
         s1_shamt_q      <= s1_shamt_d;
         s1_exp_q        <= s1_exp_d;
         s1_man_big_q    <= s1_man_big_d;
         s1_man_small_q  <= s1_man_small_d;
         s1_sign_big_q   <= s1_sign_big_d;
         s1_sign_small_q <= s1_sign_small_d;
         s2_valid_q      <= s2_valid_d;
         s2_swap_q       <= s2_swap_d;
         s2_exp_q        <= s2_exp_d;
         s2_man_big_q    <= s2_man_big_d;
         s2_sign_big_q   <= s2_sign_big_d;
         s2_sign_small_q <= s2_sign_small_d;
         s2_al_q         <= s2_al_d;
      end
   end

   assign in_ready     = w_s1_en;
   assign out_valid    = s2_valid_q;
   assign swap         = s2_swap_q;
   assign exp_big      = s2_exp_q;
   assign man_big      = s2_man_big_q;
   assign sign_big     = s2_sign_big_q;
   assign sign_small   = s2_sign_small_q;
   assign man_small_al = s2_al_q;

endmodule

`default_nettype wire
